// File: rtl/tt_pkg.sv
// Shared state encoding and defaults for the tt_top mux-spine select controller.
package tt_pkg;

    localparam int TT_ADDR_W    = 10;
    localparam int TT_N_DESIGNS = 256;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RST   = 3'd2,
        ST_ON    = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic int tt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop pad synchronizer cleared to 0 on reset, with a one-cycle pulse on each
// synchronized 0->1 transition (pulse appears two edges after the pin is sampled).
module tt_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/tt_mux_ctrl.sv
// Design-select controller: counts pad pulses into an address and walks the spine
// through disable -> settle -> load -> settle -> reset pulse -> run, all outputs registered.
module tt_mux_ctrl
    import tt_pkg::*;
#(
    parameter int ADDR_W    = TT_ADDR_W,
    parameter int N_DESIGNS = TT_N_DESIGNS,
    parameter int SETTLE    = 4,
    parameter int RST_CYC   = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sel_rst_n,
    input  logic              sel_inc,
    input  logic              sel_ena,
    output logic [ADDR_W-1:0] spine_addr,
    output logic              spine_ena,
    output logic              spine_rst_n,
    output logic              busy,
    output logic [2:0]        ctrl_oeb
);

    localparam int DW_W = $clog2(tt_max(SETTLE, RST_CYC) + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_DESIGNS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [DW_W-1:0]   DW_ONE    = DW_W'(1);

    logic w_rst_n_s;
    logic w_inc_rise;
    logic w_ena_s;
    logic w_unused_rst_rise;
    logic w_unused_inc_lvl;
    logic w_unused_ena_rise;

    tt_sync2 u_sync_rst (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_pin  (sel_rst_n),
        .o_sync (w_rst_n_s),
        .o_rise (w_unused_rst_rise)
    );

    tt_sync2 u_sync_inc (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_pin  (sel_inc),
        .o_sync (w_unused_inc_lvl),
        .o_rise (w_inc_rise)
    );

    tt_sync2 u_sync_ena (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_pin  (sel_ena),
        .o_sync (w_ena_s),
        .o_rise (w_unused_ena_rise)
    );

    // Clear beats a same-cycle increment; the counter runs in every FSM state.
    logic [ADDR_W-1:0] r_addr_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_addr_cnt <= '0;
        end else if (!w_rst_n_s) begin
            r_addr_cnt <= '0;
        end else if (w_inc_rise) begin
            r_addr_cnt <= (r_addr_cnt == ADDR_LAST) ? '0 : r_addr_cnt + ADDR_ONE;
        end
    end

    state_t            r_state;
    state_t            w_next;
    logic [DW_W-1:0]   r_dwell;
    logic [DW_W-1:0]   w_dwell_ld;
    logic [ADDR_W-1:0] r_spine_addr;
    logic              r_spine_ena;
    logic              r_spine_rst_n;
    logic              r_busy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (w_ena_s) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!w_ena_s)              w_next = ST_DRAIN;
                else if (r_dwell == '0)    w_next = ST_RST;
            end
            ST_RST: begin
                if (!w_ena_s)              w_next = ST_DRAIN;
                else if (r_dwell == '0)    w_next = ST_ON;
            end
            ST_ON: begin
                if (!w_ena_s || (r_addr_cnt != r_spine_addr)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_dwell == '0) w_next = ST_OFF;
            end
            default: w_next = ST_OFF;
        endcase
    end

    // Dwell holds remaining cycles minus one, so a state lasts exactly its budget.
    always_comb begin
        w_dwell_ld = '0;
        case (w_next)
            ST_LOAD, ST_DRAIN: w_dwell_ld = DW_W'(SETTLE - 1);
            ST_RST:            w_dwell_ld = DW_W'(RST_CYC - 1);
            default:           w_dwell_ld = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state       <= ST_OFF;
            r_dwell       <= '0;
            r_spine_addr  <= '0;
            r_spine_ena   <= 1'b0;
            r_spine_rst_n <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_dwell <= w_dwell_ld;
            end else if (r_dwell != '0) begin
                r_dwell <= r_dwell - DW_ONE;
            end
            // Address only moves on LOAD entry, where spine_ena is already low.
            if ((r_state != ST_LOAD) && (w_next == ST_LOAD)) begin
                r_spine_addr <= r_addr_cnt;
            end
            r_spine_ena   <= (w_next == ST_RST) || (w_next == ST_ON);
            r_spine_rst_n <= (w_next == ST_ON);
            r_busy        <= (w_next == ST_LOAD) || (w_next == ST_RST) || (w_next == ST_DRAIN);
        end
    end

    assign spine_addr  = r_spine_addr;
    assign spine_ena   = r_spine_ena;
    assign spine_rst_n = r_spine_rst_n;
    assign busy        = r_busy;
    assign ctrl_oeb    = 3'b111;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Bench for tt_mux_ctrl: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a plan-queue reference model.
module tb_tt_mux_ctrl;

    localparam int ADDR_W  = 10;
    localparam int N       = 256;
    localparam int SETTLE  = 4;
    localparam int RST_CYC = 8;

    logic              wb_clk_i  = 1'b0;
    logic              wb_rst_i  = 1'b1;
    logic              sel_rst_n = 1'b1;
    logic              sel_inc   = 1'b0;
    logic              sel_ena   = 1'b0;
    logic [ADDR_W-1:0] spine_addr;
    logic              spine_ena;
    logic              spine_rst_n;
    logic              busy;
    logic [2:0]        ctrl_oeb;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    tt_mux_ctrl #(
        .ADDR_W    (ADDR_W),
        .N_DESIGNS (N),
        .SETTLE    (SETTLE),
        .RST_CYC   (RST_CYC)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .sel_rst_n   (sel_rst_n),
        .sel_inc     (sel_inc),
        .sel_ena     (sel_ena),
        .spine_addr  (spine_addr),
        .spine_ena   (spine_ena),
        .spine_rst_n (spine_rst_n),
        .busy        (busy),
        .ctrl_oeb    (ctrl_oeb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each output step is {ena, rst_n, busy, abortable}. A switch
    // pushes its whole planned output sequence; an abort replaces it with a drain.
    typedef struct packed {
        logic ena;
        logic rst_n;
        logic busy;
        logic up;
    } step_t;

    step_t      m_q[$];
    step_t      m_cur;
    int         m_cnt;
    int         m_addr;
    int         m_cnt_pre;
    logic [2:0] h_ena;
    logic [2:0] h_inc;
    logic [2:0] h_rn;
    logic       m_ena_s;
    logic       m_rn_s;
    logic       m_rise;

    function automatic void plan_drain();
        m_q.delete();
        for (int i = 0; i < SETTLE; i++) m_q.push_back(step_t'(4'b0010));
        m_q.push_back(step_t'(4'b0000));
    endfunction

    function automatic void plan_up();
        m_q.delete();
        for (int i = 0; i < SETTLE; i++)  m_q.push_back(step_t'(4'b0011));
        for (int i = 0; i < RST_CYC; i++) m_q.push_back(step_t'(4'b1011));
        m_q.push_back(step_t'(4'b1100));
    endfunction

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_q.delete();
            m_cur  = '0;
            m_cnt  = 0;
            m_addr = 0;
            h_ena  = '0;
            h_inc  = '0;
            h_rn   = '0;
        end else begin
            // Pad value seen by the logic is the pin as sampled two edges earlier.
            m_ena_s   = h_ena[1];
            m_rn_s    = h_rn[1];
            m_rise    = h_inc[1] & ~h_inc[2];
            m_cnt_pre = m_cnt;
            if (!m_rn_s)     m_cnt = 0;
            else if (m_rise) m_cnt = (m_cnt + 1) % N;

            if (m_cur.up && !m_ena_s) begin
                plan_drain();
                m_cur = m_q.pop_front();
            end else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
            end else if (m_cur.ena) begin
                if (!m_ena_s || (m_cnt_pre != m_addr)) begin
                    plan_drain();
                    m_cur = m_q.pop_front();
                end
            end else if (m_ena_s) begin
                m_addr = m_cnt_pre;
                plan_up();
                m_cur = m_q.pop_front();
            end

            h_ena = {h_ena[1:0], sel_ena};
            h_inc = {h_inc[1:0], sel_inc};
            h_rn  = {h_rn[1:0], sel_rst_n};
        end
    end

    always @(negedge wb_clk_i) begin
        chk("cyc_addr",  32'(spine_addr), 32'(m_addr));
        chk("cyc_ena",   32'(spine_ena),  32'(m_cur.ena));
        chk("cyc_rst_n", 32'(spine_rst_n), 32'(m_cur.rst_n));
        chk("cyc_busy",  32'(busy),       32'(m_cur.busy));
        chk("cyc_oeb",   32'(ctrl_oeb),   32'd7);
    end

    function automatic logic [2:0] pat();
        return {spine_ena, spine_rst_n, busy};
    endfunction

    task automatic wait_pat(input logic [2:0] p, input int max, input string nm);
        int n = 0;
        while (pat() !== p && n < max) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk(nm, 32'(pat() === p), 32'd1);
    endtask

    task automatic run_len(input logic [2:0] p, output int n);
        n = 0;
        while (pat() === p && n < 200) begin
            n++;
            @(negedge wb_clk_i);
        end
    endtask

    task automatic pulse_inc();
        sel_inc = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        sel_inc = 1'b0;
        repeat (3) @(negedge wb_clk_i);
    endtask

    initial begin
        int n;
        sel_ena   = 1'b1;
        sel_rst_n = 1'b1;
        sel_inc   = 1'b0;
        wb_rst_i  = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_addr",  32'(spine_addr), 32'd0);
        chk("rst_ena",   32'(spine_ena),  32'd0);
        chk("rst_rst_n", 32'(spine_rst_n), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_oeb",   32'(ctrl_oeb),   32'd7);

        // 1) bring-up straight out of reset at address 0
        wb_rst_i = 1'b0;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("t1_latency", 32'(n), 32'd3);
        chk("t1_addr", 32'(spine_addr), 32'd0);
        run_len(3'b001, n);
        chk("t1_load_len", 32'(n), 32'd4);
        run_len(3'b101, n);
        chk("t1_rst_len", 32'(n), 32'd8);
        chk("t1_on", 32'(pat()), 32'b110);

        // 2) five pulses while disabled, then enable at address 5
        sel_ena = 1'b0;
        repeat (5) pulse_inc();
        wait_pat(3'b000, 50, "t2_off");
        sel_ena = 1'b1;
        wait_pat(3'b110, 100, "t2_on");
        chk("t2_addr", 32'(spine_addr), 32'd5);

        // 4) increment while running re-switches to address 6
        sel_inc = 1'b1;
        wait_pat(3'b001, 20, "t4_drain");
        chk("t4_drain_addr", 32'(spine_addr), 32'd5);
        run_len(3'b001, n);
        chk("t4_drain_len", 32'(n), 32'd4);
        run_len(3'b000, n);
        chk("t4_off_len", 32'(n), 32'd1);
        chk("t4_load_addr", 32'(spine_addr), 32'd6);
        run_len(3'b001, n);
        chk("t4_load_len", 32'(n), 32'd4);
        run_len(3'b101, n);
        chk("t4_rst_len", 32'(n), 32'd8);
        chk("t4_on", 32'(pat()), 32'b110);
        sel_inc = 1'b0;

        // 5) enable dropped in the middle of the reset pulse
        sel_ena = 1'b0;
        wait_pat(3'b001, 20, "t5_drain0");
        wait_pat(3'b000, 20, "t5_off0");
        sel_ena = 1'b1;
        wait_pat(3'b101, 30, "t5_rst");
        repeat (2) @(negedge wb_clk_i);
        sel_ena = 1'b0;
        n = 0;
        while (spine_ena && n < 20) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("t5_abort_latency", 32'(n), 32'd3);
        run_len(3'b001, n);
        chk("t5_drain_len", 32'(n), 32'd4);
        chk("t5_off", 32'(pat()), 32'b000);
        chk("t5_addr_held", 32'(spine_addr), 32'd6);

        // 3) clear, wrap past N-1, then clear racing an increment
        sel_rst_n = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        sel_rst_n = 1'b1;
        repeat (N + 1) pulse_inc();
        sel_ena = 1'b1;
        wait_pat(3'b110, 100, "t3_on");
        chk("t3_wrap_addr", 32'(spine_addr), 32'd1);
        sel_rst_n = 1'b0;
        sel_inc   = 1'b1;
        repeat (4) @(negedge wb_clk_i);
        sel_rst_n = 1'b1;
        sel_inc   = 1'b0;
        wait_pat(3'b001, 20, "t3_drain");
        wait_pat(3'b110, 100, "t3_on2");
        chk("t3_clear_addr", 32'(spine_addr), 32'd0);

        // 6) asynchronous reset in the middle of LOAD
        sel_ena = 1'b0;
        wait_pat(3'b001, 20, "t6_drain");
        wait_pat(3'b000, 20, "t6_off");
        pulse_inc();
        pulse_inc();
        sel_ena = 1'b1;
        wait_pat(3'b001, 30, "t6_load");
        @(posedge wb_clk_i);
        #2;
        chk("t6_pre_busy", 32'(busy), 32'd1);
        chk("t6_pre_addr", 32'(spine_addr), 32'd2);
        #1 wb_rst_i = 1'b1;
        #1;
        chk("t6_busy",  32'(busy),        32'd0);
        chk("t6_addr",  32'(spine_addr),  32'd0);
        chk("t6_ena",   32'(spine_ena),   32'd0);
        chk("t6_rst_n", 32'(spine_rst_n), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // random pad activity, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge wb_clk_i);
            if ($urandom_range(0, 99) < 25) sel_inc = ~sel_inc;
            if ($urandom_range(0, 99) < 2)  sel_ena = ~sel_ena;
            sel_rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge wb_clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
